// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - word memory behind a valid/ready request/response handshake with fixed wait latency
// Optional: define DATA_MEM_BE_CHECK_EN to reject stores with unaligned byte-enable patterns.
module data_mem_responder #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, state_next;
    logic [3:0]  cnt, cnt_next;
    logic        init_done;
    logic        accept, commit;

    logic        cap_we;
    logic [29:0] cap_word;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_be;

    logic        c_we, c_err, be_bad;
    logic [29:0] c_word;
    logic [31:0] c_wdata, c_mask;
    logic [3:0]  c_be;
    logic [AW-1:0] idx;

    logic [31:0] mem [DEPTH];

    wire unused_addr_lsbs = &{1'b0, req_addr[1:0]};

    // init_done keeps req_ready low until the first edge after reset release
    assign req_ready = (state == IDLE) && init_done;
    assign rsp_valid = (state == RESP);
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        state_next = RESP;
                        commit     = 1'b1;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = 4'(WAIT_CYCLES - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_next = RESP;
                    commit     = 1'b1;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // With zero wait the commit happens on the accept edge, so use the live request
    always_comb begin
        c_we    = (state == IDLE) ? req_we         : cap_we;
        c_word  = (state == IDLE) ? req_addr[31:2] : cap_word;
        c_wdata = (state == IDLE) ? req_wdata      : cap_wdata;
        c_be    = (state == IDLE) ? req_be         : cap_be;
        idx     = c_word[AW-1:0];
        c_mask  = {{8{c_be[3]}}, {8{c_be[2]}}, {8{c_be[1]}}, {8{c_be[0]}}};
`ifdef DATA_MEM_BE_CHECK_EN
        case (c_be)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: be_bad = 1'b0;
            default:                   be_bad = c_we;
        endcase
`else
        be_bad  = 1'b0;
`endif
        c_err   = (|c_word[29:AW]) || be_bad;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            init_done <= 1'b0;
            cap_we    <= 1'b0;
            cap_word  <= '0;
            cap_wdata <= '0;
            cap_be    <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            init_done <= 1'b1;
            if (accept) begin
                cap_we    <= req_we;
                cap_word  <= req_addr[31:2];
                cap_wdata <= req_wdata;
                cap_be    <= req_be;
            end
            if (commit) begin
                rsp_rdata <= (!c_we && !c_err) ? mem[idx] : 32'd0;
                rsp_err   <= c_err;
            end else if ((state == RESP) && rsp_ready) begin
                rsp_rdata <= 32'd0;
                rsp_err   <= 1'b0;
            end
        end
    end

    // Storage has no reset; commit can only fire out of reset since reset forces IDLE
    always_ff @(posedge clk) begin
        if (commit && c_we && !c_err)
            mem[idx] <= (mem[idx] & ~c_mask) | (c_wdata & c_mask);
    end
endmodule
